// File: rtl/regfile_wb_queue.sv
// Writeback queue ahead of the register-file write port: two producers in, one retire per cycle out.
// Define REGFILE_WB_FWD_EN to correct RD1/RD2 with the youngest pending write to the same register.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [AW-1:0]                alu_rd,
  input  logic [DW-1:0]                alu_data,
  output logic                         alu_ready,
  input  logic                         lsu_valid,
  input  logic [AW-1:0]                lsu_rd,
  input  logic [DW-1:0]                lsu_data,
  output logic                         lsu_ready,
  output logic                         WE3,
  output logic [AW-1:0]                A3,
  output logic [DW-1:0]                WD3,
  input  logic [AW-1:0]                A1,
  input  logic [AW-1:0]                A2,
  input  logic [DW-1:0]                rf_rd1,
  input  logic [DW-1:0]                rf_rd2,
  output logic [DW-1:0]                RD1,
  output logic [DW-1:0]                RD2,
  output logic [$clog2(DEPTH+1)-1:0]   pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_q   [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [CW-1:0] free;
  logic [CW-1:0] need;
  logic [PW-1:0] alu_slot;
  logic          lsu_nz, alu_nz;
  logic          lsu_push, alu_push, pop;

  // Room is judged before this cycle's retire; x0 writes are acknowledged but never take a slot.
  always_comb begin
    free      = CW'(DEPTH) - count_q;
    lsu_nz    = (lsu_rd != '0);
    alu_nz    = (alu_rd != '0);
    need      = CW'(lsu_nz) + CW'(alu_nz);
    lsu_ready = (free != '0);
    alu_ready = (free != '0) && (!lsu_valid || (free >= need));
    lsu_push  = lsu_valid && lsu_ready && lsu_nz;
    alu_push  = alu_valid && alu_ready && alu_nz;
    pop       = (count_q != '0);
    alu_slot  = tail_q + PW'(lsu_push);
    tail_d    = alu_slot + PW'(alu_push);
    head_d    = head_q + PW'(pop);
    count_d   = count_q + CW'(lsu_push) + CW'(alu_push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: only slots covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (lsu_push) begin
      rd_q[tail_q]   <= lsu_rd;
      data_q[tail_q] <= lsu_data;
    end
    if (alu_push) begin
      rd_q[alu_slot]   <= alu_rd;
      data_q[alu_slot] <= alu_data;
    end
  end

  always_comb begin
    WE3     = pop;
    A3      = pop ? rd_q[head_q]   : '0;
    WD3     = pop ? data_q[head_q] : '0;
    pending = count_q;
  end

`ifdef REGFILE_WB_FWD_EN
  // Walk oldest to youngest so the last hit is the architecturally newest value.
  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] addr, input logic [DW-1:0] raw);
    logic [DW-1:0] val;
    logic [PW-1:0] idx;
    val = raw;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr != '0) && (rd_q[idx] == addr)) begin
        val = data_q[idx];
      end
    end
    return val;
  endfunction

  always_comb begin
    RD1 = fwd(A1, rf_rd1);
    RD2 = fwd(A2, rf_rd2);
  end
`else
  logic unused_read_addr;

  always_comb begin
    RD1              = rf_rd1;
    RD2              = rf_rd2;
    unused_read_addr = ^{A1, A2};
  end
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: queue-based reference model plus directed literal checks
// followed by a randomized phase; forwarding expectations follow REGFILE_WB_FWD_EN.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
`ifdef REGFILE_WB_FWD_EN
  localparam bit fwdEn = 1'b1;
`else
  localparam bit fwdEn = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk;
  logic          rst;
  logic          alu_valid, lsu_valid;
  logic [AW-1:0] alu_rd, lsu_rd;
  logic [DW-1:0] alu_data, lsu_data;
  logic          alu_ready, lsu_ready;
  logic          WE3;
  logic [AW-1:0] A3, A1, A2;
  logic [DW-1:0] WD3, rf_rd1, rf_rd2, RD1, RD2;
  logic [$clog2(DEPTH+1)-1:0] pending;

  entry_t modelQ[$];
  int     nChecks;
  int     nFails;

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .A1(A1), .A2(A2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .RD1(RD1), .RD2(RD2), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference read: newest queued write to a nonzero register wins, else the raw file value.
  function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] addr, input logic [DW-1:0] raw);
    if (fwdEn && addr != '0) begin
      for (int i = modelQ.size() - 1; i >= 0; i--) begin
        if (modelQ[i].rd == addr) return modelQ[i].data;
      end
    end
    return raw;
  endfunction

  function automatic bit modelLsuReady();
    return (DEPTH - modelQ.size()) >= 1;
  endfunction

  function automatic bit modelAluReady();
    int freeSlots;
    int wanted;
    freeSlots = DEPTH - modelQ.size();
    wanted    = int'(lsu_rd != '0) + int'(alu_rd != '0);
    return (freeSlots >= 1) && (!lsu_valid || freeSlots >= wanted);
  endfunction

  task automatic checkOutput();
    bit busy;
    busy = (modelQ.size() != 0);
    check("lsu_ready", 64'(lsu_ready), 64'(modelLsuReady()));
    check("alu_ready", 64'(alu_ready), 64'(modelAluReady()));
    check("WE3",       64'(WE3),       64'(busy));
    check("A3",        64'(A3),        busy ? 64'(modelQ[0].rd)   : 64'd0);
    check("WD3",       64'(WD3),       busy ? 64'(modelQ[0].data) : 64'd0);
    check("pending",   64'(pending),   64'(modelQ.size()));
    check("RD1",       64'(RD1),       64'(modelRead(A1, rf_rd1)));
    check("RD2",       64'(RD2),       64'(modelRead(A2, rf_rd2)));
  endtask

  task automatic applyStimulus(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                               input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldat,
                               input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                               input logic [DW-1:0] r1, input logic [DW-1:0] r2);
    @(negedge clk);
    alu_valid = av;  alu_rd = ard;  alu_data = adat;
    lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ldat;
    A1 = a1;  A2 = a2;  rf_rd1 = r1;  rf_rd2 = r2;
    #1;
    checkOutput();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, '0, '0, '0);
  endtask

  // Advance one clock: one retire from the front, then the LSU entry, then the ALU entry.
  task automatic tick();
    bit takeL, takeA;
    entry_t e;
    takeL = lsu_valid && modelLsuReady() && (lsu_rd != '0);
    takeA = alu_valid && modelAluReady() && (alu_rd != '0);
    @(posedge clk);
    if (modelQ.size() != 0) void'(modelQ.pop_front());
    if (takeL) begin e.rd = lsu_rd; e.data = lsu_data; modelQ.push_back(e); end
    if (takeA) begin e.rd = alu_rd; e.data = alu_data; modelQ.push_back(e); end
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    rst = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    A1 = '0; A2 = '0; rf_rd1 = '0; rf_rd2 = '0;

    // Reset state
    @(negedge clk); #1;
    check("rst_WE3", 64'(WE3), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_lsu_ready", 64'(lsu_ready), 64'd1);
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    // Single ALU write into an empty queue retires the following cycle
    applyStimulus(1'b1, 5'd5, 32'h20, 1'b0, '0, '0, '0, '0, '0, '0);
    check("single_accept", 64'(alu_ready), 64'd1);
    check("single_noWE_same", 64'(WE3), 64'd0);
    tick();
    idleCycle();
    check("single_WE3", 64'(WE3), 64'd1);
    check("single_A3", 64'(A3), 64'd5);
    check("single_WD3", 64'(WD3), 64'h20);
    tick();
    idleCycle();
    check("single_done", 64'(WE3), 64'd0);
    tick();

    // Dual enqueue retires LSU first, then ALU
    applyStimulus(1'b1, 5'd7, 32'h22, 1'b1, 5'd6, 32'h11, '0, '0, '0, '0);
    tick();
    idleCycle();
    check("dual_pend2", 64'(pending), 64'd2);
    check("dual_A3_first", 64'(A3), 64'd6);
    check("dual_WD3_first", 64'(WD3), 64'h11);
    tick();
    idleCycle();
    check("dual_pend1", 64'(pending), 64'd1);
    check("dual_A3_second", 64'(A3), 64'd7);
    check("dual_WD3_second", 64'(WD3), 64'h22);
    tick();
    idleCycle();
    check("dual_pend0", 64'(pending), 64'd0);
    tick();

    // Build up to three pending; at free=1 only the LSU is taken
    applyStimulus(1'b1, 5'd2, 32'h102, 1'b1, 5'd1, 32'h101, '0, '0, '0, '0);
    tick();
    applyStimulus(1'b1, 5'd4, 32'h104, 1'b1, 5'd3, 32'h103, '0, '0, '0, '0);
    check("fill_alu_ready_free2", 64'(alu_ready), 64'd1);
    tick();
    applyStimulus(1'b1, 5'd9, 32'h109, 1'b1, 5'd8, 32'h108, '0, '0, '0, '0);
    check("fill_pend3", 64'(pending), 64'd3);
    check("fill_lsu_ready_free1", 64'(lsu_ready), 64'd1);
    check("fill_alu_ready_free1", 64'(alu_ready), 64'd0);
    tick();

    // Reset in the middle of a three-entry drain kills the write immediately
    idleCycle();
    check("drain_pend3", 64'(pending), 64'd3);
    check("drain_WE3", 64'(WE3), 64'd1);
    rst = 1'b0;
    #1;
    check("midrst_WE3", 64'(WE3), 64'd0);
    check("midrst_pending", 64'(pending), 64'd0);
    modelQ.delete();
    @(negedge clk);
    rst = 1'b1;

    // Writes to x0 are acknowledged but never queued
    applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, '0, '0, '0, '0, '0, '0);
    check("x0_accept", 64'(alu_ready), 64'd1);
    tick();
    idleCycle();
    check("x0_pending", 64'(pending), 64'd0);
    check("x0_noWE", 64'(WE3), 64'd0);
    tick();

    // Two writes to x3 pending: the younger one must be seen on RD1
    applyStimulus(1'b1, 5'd3, 32'hB, 1'b1, 5'd3, 32'hA, '0, '0, '0, '0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 5'd3, 5'd0, fwdEn ? 32'h0 : 32'h55, 32'h0);
    check("fwd_RD1", 64'(RD1), fwdEn ? 64'hB : 64'h55);
    check("fwd_RD2_x0", 64'(RD2), 64'd0);
    tick();
    idleCycle();
    tick();
    idleCycle();
    tick();

    // Randomized traffic with small register numbers to provoke matches and x0 writes
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
